// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and FSM encoding for the synchronous instruction memory.
package imem_pkg;

    // Word returned for out-of-range fetches and written by the clear sweep.
    localparam logic [31:0] NOOP_WORD = 32'h0;

    // Deepest supported read pipeline.
    localparam int LAT_MAX = 4;

    // CLEAR zero-fills the array after reset; READY serves traffic until the next reset.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage : imem_pkg

// File: rtl/imem_sync_if.sv
// imem_sync_if: fetch handshake and program-load bundle of imem_sync.
// Build option: defining IMEM_PARITY_EN adds inj_par_flip (master->slave)
// and parity_err (slave->master).
interface imem_sync_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);

    logic              fetch_req;
    logic [31:0]       PC;
    logic              ready;
    logic              instr_valid;
    logic [DATA_W-1:0] Instruction;
    logic              addr_err;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
`ifdef IMEM_PARITY_EN
    logic              inj_par_flip;
    logic              parity_err;
`endif

`ifdef IMEM_PARITY_EN
    modport master (
        output fetch_req, PC, prog_we, prog_addr, prog_data, inj_par_flip,
        input  ready, instr_valid, Instruction, addr_err, parity_err
    );
    modport slave (
        input  fetch_req, PC, prog_we, prog_addr, prog_data, inj_par_flip,
        output ready, instr_valid, Instruction, addr_err, parity_err
    );
`else
    modport master (
        output fetch_req, PC, prog_we, prog_addr, prog_data,
        input  ready, instr_valid, Instruction, addr_err
    );
    modport slave (
        input  fetch_req, PC, prog_we, prog_addr, prog_data,
        output ready, instr_valid, Instruction, addr_err
    );
`endif

endinterface : imem_sync_if

// File: rtl/imem_rd_pipe.sv
// imem_rd_pipe: LATENCY-deep {valid, err, data} delay line for fetch results.
// Stage 1 captures the memory read; the last stage drives the outputs.
// Data stages only load on a valid beat so the output word holds between fetches;
// err is qualified by valid so it is never set on an idle cycle.
module imem_rd_pipe #(
    parameter int LATENCY = 1,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [LATENCY-1:0] err_q,   err_d;
    logic [DATA_W-1:0]  data_q [LATENCY];
    logic [DATA_W-1:0]  data_d [LATENCY];

    // Next-stage values: shift every stage forward by one.
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
        valid_d[0] = in_valid;
        err_d[0]   = in_valid & in_err;
        data_d[0]  = in_valid ? in_data : data_q[0];
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
            data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    // Stage registers; reset flushes any in-flight fetch.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all stages shift from the same pre-edge values.
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int i = 0; i < LATENCY; i++) data_q[i] <= data_d[i];
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule : imem_rd_pipe

// File: rtl/imem_sync.sv
// imem_sync: synchronous instruction memory with runtime program load,
// zero-fill after reset and a fixed-latency fetch pipeline.
// Build option: IMEM_PARITY_EN stores an even-parity bit per word and reports
// mismatches on parity_err.
module imem_sync
    import imem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input logic        clk,
    input logic        rst_n,
    imem_sync_if.slave bus
);

`ifdef IMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = DATA_W + PAR_W;
    localparam int LAT_C = (LATENCY > LAT_MAX) ? LAT_MAX : ((LATENCY < 1) ? 1 : LATENCY);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              clr_we;
    logic              ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [MEM_W-1:0]  wr_word;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  rd_word;
    logic              rd_in_range;
    logic              pipe_in_err;
    logic [MEM_W-1:0]  pipe_in_data;
    logic              pipe_out_valid;
    logic              pipe_out_err;
    logic [MEM_W-1:0]  pipe_out_data;

    // FSM next state: sweep the clear pointer once, then stay READY.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = READY;
                    clr_ptr_d = '0;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // FSM state register; reset restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    assign ready     = (state_q == READY);
    assign bus.ready = ready;

    // Write port select: clear sweep owns the port until READY, then program writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_ptr_q;
        wr_word = '0;
        if (clr_we) begin
            wr_en = 1'b1;
        end else if (ready && bus.prog_we && (32'(bus.prog_addr) < 32'(DEPTH))) begin
            wr_en   = 1'b1;
            wr_addr = bus.prog_addr;
`ifdef IMEM_PARITY_EN
            wr_word = {(^bus.prog_data) ^ bus.inj_par_flip, bus.prog_data};
`else
            wr_word = bus.prog_data;
`endif
        end
        wr_en = wr_en & rst_n;
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; the CLEAR sweep zero-fills it after every reset.
        if (wr_en) mem[wr_addr] <= wr_word;
    end

    // The whole 32-bit PC is compared, so any non-zero upper bit is out of range.
    assign rd_in_range = (bus.PC < 32'(DEPTH));
    assign rd_word     = mem[bus.PC[ADDR_W-1:0]];

    // Stage-0 fetch result: stored word (plus parity verdict) or NOOP with err.
    always_comb begin
        pipe_in_data               = '0;
        pipe_in_data[DATA_W-1:0]   = DATA_W'(NOOP_WORD);
        pipe_in_err                = 1'b1;
        if (rd_in_range) begin
            pipe_in_err = 1'b0;
`ifdef IMEM_PARITY_EN
            pipe_in_data = {(^rd_word[DATA_W-1:0]) ^ rd_word[DATA_W], rd_word[DATA_W-1:0]};
`else
            pipe_in_data = rd_word;
`endif
        end
    end

    imem_rd_pipe #(
        .LATENCY (LAT_C),
        .DATA_W  (MEM_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (ready & bus.fetch_req),
        .in_err    (pipe_in_err),
        .in_data   (pipe_in_data),
        .out_valid (pipe_out_valid),
        .out_err   (pipe_out_err),
        .out_data  (pipe_out_data)
    );

    assign bus.instr_valid = pipe_out_valid;
    assign bus.addr_err    = pipe_out_err;
    assign bus.Instruction = pipe_out_data[DATA_W-1:0];
`ifdef IMEM_PARITY_EN
    assign bus.parity_err  = pipe_out_valid & pipe_out_data[DATA_W];
`endif

endmodule : imem_sync

// File: tb/tb_imem_sync.sv
// tb_imem_sync: two instances (A: DEPTH 256 / LATENCY 1, B: DEPTH 200 / LATENCY 3)
// driven with directed and random traffic; a memory-array model and an expected
// result queue per instance predict every output cycle.
module tb_imem_sync;

    localparam int DEPTH_A = 256;
    localparam int LAT_A   = 1;
    localparam int DEPTH_B = 200;
    localparam int LAT_B   = 3;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
        logic        perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_sync_if #(.DATA_W(32), .ADDR_W(8)) bus_a ();
    imem_sync_if #(.DATA_W(32), .ADDR_W(8)) bus_b ();

    imem_sync #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH_A), .LATENCY(LAT_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_a_n),
        .bus   (bus_a.slave)
    );

    imem_sync #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH_B), .LATENCY(LAT_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .bus   (bus_b.slave)
    );

    logic pe_a, pe_b;
`ifdef IMEM_PARITY_EN
    assign pe_a = bus_a.parity_err;
    assign pe_b = bus_b.parity_err;
`else
    assign pe_a = 1'b0;
    assign pe_b = 1'b0;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model [2][256];
    bit          bad   [2][256];
    logic [31:0] last_ins [2];
    exp_t        q_a[$], q_b[$];
    exp_t        log_a[$], log_b[$];

    task automatic zero_model(input int w);
        for (int i = 0; i < 256; i++) begin
            model[w][i] = 32'h0;
            bad[w][i]   = 1'b0;
        end
    endtask

    // Per-cycle scoreboard for one instance.
    task automatic mon(input int w, input logic rn, input logic v, input logic e,
                       input logic [31:0] ins, input logic pe);
        exp_t h;
        exp_t o;
        bit   due;
        due = 1'b0;
        if (w == 0) begin
            if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin due = 1'b1; h = q_a.pop_front(); end
        end else begin
            if (q_b.size() > 0 && q_b[0].cyc <= cyc) begin due = 1'b1; h = q_b.pop_front(); end
        end
        n_checks++;
        if (!rn) begin
            if (v !== 1'b0 || e !== 1'b0 || ins !== 32'h0 || pe !== 1'b0)
                $display("FAIL reset_outputs[%0d] cyc=%0d: valid=%b err=%b instr=%h perr=%b, required all 0",
                         w, cyc, v, e, ins, pe);
            else n_pass++;
            last_ins[w] = 32'h0;
        end else if (v === 1'b1) begin
            o.cyc = cyc; o.err = e; o.data = ins; o.perr = pe;
            if (w == 0) log_a.push_back(o); else log_b.push_back(o);
            if (!due)
                $display("FAIL unexpected_valid[%0d] cyc=%0d: instr=%h err=%b, required no valid", w, cyc, ins, e);
            else if (h.cyc != cyc || ins !== h.data || e !== h.err || pe !== h.perr)
                $display("FAIL fetch_result[%0d] cyc=%0d: instr=%h err=%b perr=%b, required cyc=%0d instr=%h err=%b perr=%b",
                         w, cyc, ins, e, pe, h.cyc, h.data, h.err, h.perr);
            else n_pass++;
            last_ins[w] = due ? h.data : ins;
        end else begin
            if (due)
                $display("FAIL missing_valid[%0d] cyc=%0d: valid=%b, required valid instr=%h", w, cyc, v, h.data);
            else if (v !== 1'b0 || e !== 1'b0 || pe !== 1'b0 || ins !== last_ins[w])
                $display("FAIL idle_outputs[%0d] cyc=%0d: valid=%b err=%b perr=%b instr=%h, required 0/0/0 instr=%h",
                         w, cyc, v, e, pe, ins, last_ins[w]);
            else n_pass++;
        end
    endtask

    always @(negedge clk) begin
        mon(0, rst_a_n, bus_a.instr_valid, bus_a.addr_err, bus_a.Instruction, pe_a);
        mon(1, rst_b_n, bus_b.instr_valid, bus_b.addr_err, bus_b.Instruction, pe_b);
    end

    task automatic idle_inputs();
        bus_a.fetch_req = 1'b0; bus_a.PC = 32'h0; bus_a.prog_we = 1'b0; bus_a.prog_addr = 8'h0; bus_a.prog_data = 32'h0;
        bus_b.fetch_req = 1'b0; bus_b.PC = 32'h0; bus_b.prog_we = 1'b0; bus_b.prog_addr = 8'h0; bus_b.prog_data = 32'h0;
`ifdef IMEM_PARITY_EN
        bus_a.inj_par_flip = 1'b0;
        bus_b.inj_par_flip = 1'b0;
`endif
    endtask

    // One cycle of stimulus on instance w (other instance idle); updates the model when accepted.
    task automatic step(input int w, input bit fr, input logic [31:0] pc, input bit we,
                        input logic [7:0] wa, input logic [31:0] wd, input bit flip);
        exp_t h;
        int   dep, lat;
        bit   rdy, fl;
        fl = flip;
`ifndef IMEM_PARITY_EN
        fl = 1'b0;
`endif
        @(negedge clk); #1;
        idle_inputs();
        dep = (w == 0) ? DEPTH_A : DEPTH_B;
        lat = (w == 0) ? LAT_A : LAT_B;
        if (w == 0) begin
            bus_a.fetch_req = fr; bus_a.PC = pc; bus_a.prog_we = we; bus_a.prog_addr = wa; bus_a.prog_data = wd;
`ifdef IMEM_PARITY_EN
            bus_a.inj_par_flip = fl;
`endif
            rdy = (bus_a.ready === 1'b1);
        end else begin
            bus_b.fetch_req = fr; bus_b.PC = pc; bus_b.prog_we = we; bus_b.prog_addr = wa; bus_b.prog_data = wd;
`ifdef IMEM_PARITY_EN
            bus_b.inj_par_flip = fl;
`endif
            rdy = (bus_b.ready === 1'b1);
        end
        if (rdy) begin
            if (fr) begin
                h.cyc = cyc + lat;
                if (pc < 32'(dep)) begin
                    h.err = 1'b0; h.data = model[w][pc[7:0]]; h.perr = bad[w][pc[7:0]];
                end else begin
                    h.err = 1'b1; h.data = 32'h0; h.perr = 1'b0;
                end
                if (w == 0) q_a.push_back(h); else q_b.push_back(h);
            end
            if (we && 32'(wa) < 32'(dep)) begin
                model[w][wa] = wd;
                bad[w][wa]   = fl;
            end
        end
    endtask

    task automatic drain();
        repeat (8) step(0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0, 1'b0);
        n_checks++;
        if (q_a.size() != 0 || q_b.size() != 0)
            $display("FAIL drain: pending A=%0d B=%0d, required 0/0", q_a.size(), q_b.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        int k, k_a, k_b;
        @(negedge clk); #1;
        bus_a.fetch_req = 1'b1; bus_a.prog_we = 1'b1;
        bus_b.fetch_req = 1'b1; bus_b.prog_we = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_a.ready !== 1'b0 || bus_b.ready !== 1'b0)
            $display("FAIL reset_ready: A=%b B=%b, required 0/0", bus_a.ready, bus_b.ready);
        else n_pass++;
        #1;
        idle_inputs();
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        k = 0; k_a = -1; k_b = -1;
        while ((k_a < 0 || k_b < 0) && k < 1000) begin
            @(negedge clk);
            k++;
            if (k_a < 0 && bus_a.ready === 1'b1) k_a = k;
            if (k_b < 0 && bus_b.ready === 1'b1) k_b = k;
            #1;
            // Traffic while clearing must be ignored.
            bus_a.fetch_req = (k_a < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_a.prog_we   = (k_a < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_a.PC        = 32'($urandom_range(0, 255));
            bus_a.prog_addr = 8'($urandom);
            bus_a.prog_data = $urandom;
            bus_b.fetch_req = (k_b < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_b.prog_we   = (k_b < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_b.PC        = 32'($urandom_range(0, 255));
            bus_b.prog_addr = 8'($urandom);
            bus_b.prog_data = $urandom;
        end
        idle_inputs();
        n_checks++;
        if (k_a != DEPTH_A) $display("FAIL clear_len_a: ready after %0d cycles, required %0d", k_a, DEPTH_A);
        else n_pass++;
        n_checks++;
        if (k_b != DEPTH_B) $display("FAIL clear_len_b: ready after %0d cycles, required %0d", k_b, DEPTH_B);
        else n_pass++;
    endtask

    task automatic test_clear_zero();
        int nz;
        log_a.delete();
        for (int pc = 0; pc < DEPTH_A; pc++) step(0, 1'b1, 32'(pc), 1'b0, 8'h0, 32'h0, 1'b0);
        for (int pc = 0; pc < DEPTH_B; pc++) step(1, 1'b1, 32'(pc), 1'b0, 8'h0, 32'h0, 1'b0);
        drain();
        nz = 0;
        foreach (log_a[i]) if (log_a[i].data !== 32'h0 || log_a[i].err !== 1'b0) nz++;
        n_checks++;
        if (log_a.size() != DEPTH_A || nz != 0)
            $display("FAIL clear_zero: %0d results, %0d non-zero, required %0d results, 0 non-zero",
                     log_a.size(), nz, DEPTH_A);
        else n_pass++;
    endtask

    task automatic test_load_fetch();
        int t0;
        step(0, 1'b0, 32'h0, 1'b1, 8'd0, 32'hE400FFFF, 1'b0);
        step(0, 1'b0, 32'h0, 1'b1, 8'd1, 32'hE800FFFF, 1'b0);
        log_a.delete();
        step(0, 1'b1, 32'd0, 1'b0, 8'h0, 32'h0, 1'b0);
        t0 = cyc;
        step(0, 1'b1, 32'd1, 1'b0, 8'h0, 32'h0, 1'b0);
        drain();
        n_checks++;
        if (log_a.size() != 2 || log_a[0].cyc != t0 + 1 || log_a[0].data !== 32'hE400FFFF ||
            log_a[1].cyc != t0 + 2 || log_a[1].data !== 32'hE800FFFF)
            $display("FAIL load_fetch: n=%0d first=%h@%0d second=%h@%0d, required E400FFFF@%0d E800FFFF@%0d",
                     log_a.size(), (log_a.size() > 0) ? log_a[0].data : 32'hx, (log_a.size() > 0) ? log_a[0].cyc : -1,
                     (log_a.size() > 1) ? log_a[1].data : 32'hx, (log_a.size() > 1) ? log_a[1].cyc : -1, t0 + 1, t0 + 2);
        else n_pass++;
    endtask

    task automatic test_latency();
        int t0;
        for (int i = 0; i < 20; i++) step(1, 1'b0, 32'h0, 1'b1, 8'(i), $urandom, 1'b0);
        log_b.delete();
        t0 = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1'b1, 32'($urandom_range(0, DEPTH_B - 1)), 1'b0, 8'h0, 32'h0, 1'b0);
            if (i == 0) t0 = cyc;
        end
        drain();
        n_checks++;
        if (log_b.size() != 10) $display("FAIL latency_count: %0d valids, required 10", log_b.size());
        else n_pass++;
        foreach (log_b[i]) begin
            n_checks++;
            if (log_b[i].cyc != t0 + 3 + i)
                $display("FAIL latency_cycle[%0d]: valid at %0d, required %0d", i, log_b[i].cyc, t0 + 3 + i);
            else n_pass++;
        end
    endtask

    task automatic test_boundary();
        logic [31:0] r, r2;
        r  = $urandom;
        r2 = $urandom | 32'h1;
        step(0, 1'b0, 32'h0, 1'b1, 8'd255, r, 1'b0);
        log_a.delete();
        step(0, 1'b1, 32'd255, 1'b0, 8'h0, 32'h0, 1'b0);
        step(0, 1'b1, 32'd256, 1'b0, 8'h0, 32'h0, 1'b0);
        step(0, 1'b1, 32'h0001_0000, 1'b0, 8'h0, 32'h0, 1'b0);
        drain();
        n_checks++;
        if (log_a.size() != 3 || log_a[0].data !== r || log_a[0].err !== 1'b0 ||
            log_a[1].data !== 32'h0 || log_a[1].err !== 1'b1 || log_a[2].data !== 32'h0 || log_a[2].err !== 1'b1)
            $display("FAIL boundary_a: n=%0d, required %h/0 then 0/1 twice", log_a.size(), r);
        else n_pass++;
        step(1, 1'b0, 32'h0, 1'b1, 8'd199, r2, 1'b0);
        for (int a = DEPTH_B; a < 256; a++) step(1, 1'b0, 32'h0, 1'b1, 8'(a), $urandom | 32'h1, 1'b0);
        log_b.delete();
        step(1, 1'b1, 32'd199, 1'b0, 8'h0, 32'h0, 1'b0);
        step(1, 1'b1, 32'(DEPTH_B), 1'b0, 8'h0, 32'h0, 1'b0);
        drain();
        n_checks++;
        if (log_b.size() != 2 || log_b[0].data !== r2 || log_b[0].err !== 1'b0 ||
            log_b[1].data !== 32'h0 || log_b[1].err !== 1'b1)
            $display("FAIL boundary_b: n=%0d, required %h/0 then 0/1", log_b.size(), r2);
        else n_pass++;
        // Dropped writes must not have touched any stored word.
        for (int pc = 0; pc < DEPTH_B; pc++) step(1, 1'b1, 32'(pc), 1'b0, 8'h0, 32'h0, 1'b0);
        drain();
    endtask

    task automatic test_collision();
        step(0, 1'b0, 32'h0, 1'b1, 8'd5, 32'hCAFE0005, 1'b0);
        log_a.delete();
        step(0, 1'b1, 32'd5, 1'b1, 8'd5, 32'h0000_1234, 1'b0);
        step(0, 1'b1, 32'd5, 1'b0, 8'h0, 32'h0, 1'b0);
        drain();
        n_checks++;
        if (log_a.size() != 2 || log_a[0].data !== 32'hCAFE0005 || log_a[1].data !== 32'h0000_1234)
            $display("FAIL collision: n=%0d got %h,%h, required CAFE0005,00001234", log_a.size(),
                     (log_a.size() > 0) ? log_a[0].data : 32'hx, (log_a.size() > 1) ? log_a[1].data : 32'hx);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int i = 0; i < 600; i++) begin
            pc = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 270));
            step(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)),
                 8'($urandom), $urandom, ($urandom_range(0, 7) == 0));
        end
        drain();
    endtask

    task automatic test_midop_reset();
        int k;
        step(1, 1'b0, 32'h0, 1'b1, 8'd5, 32'h0000_ABCD, 1'b0);
        step(1, 1'b1, 32'd5, 1'b0, 8'h0, 32'h0, 1'b0);
        step(1, 1'b1, 32'd7, 1'b0, 8'h0, 32'h0, 1'b0);
        @(negedge clk); #1;
        idle_inputs();
        rst_b_n = 1'b0;
        q_b.delete();
        log_b.delete();
        zero_model(1);
        @(negedge clk);
        n_checks++;
        if (bus_b.ready !== 1'b0) $display("FAIL midop_ready: ready=%b, required 0", bus_b.ready);
        else n_pass++;
        @(negedge clk); #1;
        rst_b_n = 1'b1;
        k = 0;
        while (bus_b.ready !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != DEPTH_B) $display("FAIL midop_clear_len: ready after %0d cycles, required %0d", k, DEPTH_B);
        else n_pass++;
        n_checks++;
        if (log_b.size() != 0) $display("FAIL midop_flush: %0d valids, required 0", log_b.size());
        else n_pass++;
        step(1, 1'b1, 32'd5, 1'b0, 8'h0, 32'h0, 1'b0);
        drain();
        n_checks++;
        if (log_b.size() != 1 || log_b[0].data !== 32'h0)
            $display("FAIL midop_addr5: n=%0d, required one result of 00000000", log_b.size());
        else n_pass++;
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        step(0, 1'b0, 32'h0, 1'b1, 8'd9, 32'h3, 1'b1);
        log_a.delete();
        step(0, 1'b1, 32'd9, 1'b0, 8'h0, 32'h0, 1'b0);
        step(0, 1'b0, 32'h0, 1'b1, 8'd9, 32'h3, 1'b0);
        step(0, 1'b1, 32'd9, 1'b0, 8'h0, 32'h0, 1'b0);
        drain();
        n_checks++;
        if (log_a.size() != 2 || log_a[0].perr !== 1'b1 || log_a[1].perr !== 1'b0)
            $display("FAIL parity: n=%0d, required parity_err 1 then 0", log_a.size());
        else n_pass++;
    endtask
`endif

    initial begin
        idle_inputs();
        zero_model(0);
        zero_model(1);
        last_ins[0] = 32'h0;
        last_ins[1] = 32'h0;
        test_reset();
        test_clear_zero();
        test_load_fetch();
        test_latency();
        test_boundary();
        test_collision();
        test_random();
        test_midop_reset();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_imem_sync
